// File: rtl/sb_deser_pkg.sv
// Shared types and constants for the sideband deserializer.
package sb_deser_pkg;

  // Assembly FSM: IDLE while the bit counter is zero, RECV while a frame is partial.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  // Bit-order selectors for the MSB_FIRST parameter.
  localparam int ORDER_LSB_FIRST = 0;
  localparam int ORDER_MSB_FIRST = 1;

endpackage

// File: rtl/sb_deser_out_buf.sv
// One-entry ready/valid holding register for completed frames.
// Handshake: a frame transfers on a cycle where out_valid && out_ready; out_data
// is held stable while out_valid is high. A load is accepted whenever the entry
// is empty or is being drained in the same cycle (can_load).
module sb_deser_out_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next entry state: a fresh frame wins over a drain in the same cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load && can_load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sb_deserializer_hs.sv
// Sideband serial-to-parallel converter with ready/valid output, gap abort and
// sticky overflow. Optional drop counter enabled by SB_DESER_DROP_CNT_EN.
module sb_deserializer_hs
  import sb_deser_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int WIDTH_W   = $clog2(WIDTH),
  parameter int MSB_FIRST = 0,
  parameter int GAP_MAX   = 32,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_abort,
  output logic             overflow,
  input  logic             clear_err
`ifdef SB_DESER_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  // Gap counter is sized so GAP_MAX fits even when GAP_MAX is 0 or 1.
  localparam int                 GAP_W    = $clog2(GAP_MAX + 2);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP_MAX > 0) ? GAP_MAX - 1 : 0);
  localparam logic [WIDTH_W-1:0] CNT_LAST = WIDTH_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH_W-1:0] cnt_q, cnt_d, idx;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]   asm_q, asm_d, frame;
  logic               busy_q, abort_q, ovf_q, ovf_d;
  logic               frame_done, gap_hit, can_load, drop;

  // Bit placement and the assembly word including the current bit.
  always_comb begin
    idx   = (MSB_FIRST == ORDER_MSB_FIRST) ? (CNT_LAST - cnt_q) : cnt_q;
    frame = asm_q;
    frame[idx] = in_data;
  end

  assign frame_done = in_valid && (cnt_q == CNT_LAST);
  // Abort fires on the GAP_MAX-th consecutive idle cycle of a partial frame.
  assign gap_hit    = (GAP_MAX != 0) && (state_q == ST_RECV) && !in_valid && (gap_q == GAP_LAST);
  assign drop       = frame_done && !can_load;

  // FSM next state, bit counter, gap timer and assembly register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = '0;
    asm_d   = asm_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RECV;
          cnt_d   = cnt_q + 1'b1;
          asm_d   = frame;
        end
      end
      ST_RECV: begin
        if (in_valid) begin
          if (frame_done) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            asm_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            asm_d = frame;
          end
        end else if (gap_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          asm_d   = '0;
        end else if (GAP_MAX != 0) begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow: a drop in the same cycle beats clear_err.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_err) ovf_d = 1'b0;
  end

  // State, counters and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      asm_q   <= '0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      asm_q   <= asm_d;
      busy_q  <= (cnt_d != '0);
      abort_q <= gap_hit;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign frame_abort = abort_q;
  assign overflow    = ovf_q;

  sb_deser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (frame_done),
    .load_data (frame),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .can_load  (can_load)
  );

`ifdef SB_DESER_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; an increment beats clear_err.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (clear_err) begin
      drop_cnt_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
